// File: rtl/spi_flash_responder.sv
// SPI flash responder: serves READ (0x03) from a loadable byte store, oversampling SPI on clk.
// Define SPI_FAST_READ_EN to also accept FAST READ (0x0B) with an 8-clock DUMMY phase.
module spi_flash_responder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy
);
    // state  | meaning
    // IDLE   | CS high, no transaction
    // CMD    | shifting in 8 command bits
    // ADDR   | shifting in 24 address bits
    // DUMMY  | fast read only: 8 don't-care clocks, MISO undriven
    // DATA   | serving store bytes on MISO
    // IGNORE | unsupported command, wait for CS high
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
`ifdef SPI_FAST_READ_EN
        DUMMY  = 3'd3,
`endif
        DATA   = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_s, cs_s;
    logic        sck_d, mosi_d, sck_rise, sck_fall;
    logic [4:0]  cnt;
    logic [6:0]  cmd_sr;
    logic [7:0]  cmd_next;
    logic [23:0] addr;
    logic [7:0]  shift_reg;
    logic [7:0]  fetch_byte;
    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic        unused_addr_bits;
`ifdef SPI_FAST_READ_EN
    logic        is_fast;
`endif

    assign sck_s            = sck_sync[1];
    assign cs_s             = cs_sync[1];
    assign cmd_next         = {cmd_sr, mosi_d};
    assign fetch_byte       = mem[addr[ADDR_W-1:0]];
    assign busy             = (state != IDLE);
    assign unused_addr_bits = ^addr[23:ADDR_W];

    // Edge pulses are registered so MOSI (also delayed once) lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            mosi_d    <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_d     <= sck_s;
            mosi_d    <= mosi_sync[1];
            sck_rise  <= sck_s & ~sck_d;
            sck_fall  <= ~sck_s & sck_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_s) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = CMD;
                CMD: begin
                    if (sck_rise && cnt == 5'd7) begin
                        if (cmd_next == 8'h03)
                            state_n = ADDR;
`ifdef SPI_FAST_READ_EN
                        else if (cmd_next == 8'h0B)
                            state_n = ADDR;
`endif
                        else
                            state_n = IGNORE;
                    end
                end
                ADDR: begin
                    if (sck_rise && cnt == 5'd23) begin
`ifdef SPI_FAST_READ_EN
                        state_n = is_fast ? DUMMY : DATA;
`else
                        state_n = DATA;
`endif
                    end
                end
`ifdef SPI_FAST_READ_EN
                DUMMY: begin
                    if (sck_rise && cnt == 5'd7)
                        state_n = DATA;
                end
`endif
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            cmd_sr      <= '0;
            addr        <= '0;
            shift_reg   <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
`ifdef SPI_FAST_READ_EN
            is_fast     <= 1'b0;
`endif
        end else if (cs_s) begin
            cnt         <= '0;
            cmd_sr      <= '0;
            addr        <= '0;
            shift_reg   <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
`ifdef SPI_FAST_READ_EN
            is_fast     <= 1'b0;
`endif
        end else begin
            case (state)
                CMD: begin
                    if (sck_rise) begin
                        cmd_sr <= cmd_next[6:0];
                        cnt    <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
`ifdef SPI_FAST_READ_EN
                        is_fast <= (cmd_next == 8'h0B);
`endif
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr <= {addr[22:0], mosi_d};
                        cnt  <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
                    end
                end
`ifdef SPI_FAST_READ_EN
                DUMMY: begin
                    if (sck_rise)
                        cnt <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
                end
`endif
                DATA: begin
                    if (sck_rise)
                        cnt <= {2'b00, cnt[2:0] + 3'd1};
                    if (sck_fall) begin
                        spi_miso_oe <= 1'b1;
                        if (cnt[2:0] == 3'd0) begin
                            shift_reg <= fetch_byte;
                            spi_miso  <= fetch_byte[7];
                            addr      <= addr + 24'd1;
                        end else begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            spi_miso  <= shift_reg[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: byte-level SPI master against an array model of the store.
// Honours SPI_FAST_READ_EN to pick the expected fast-read behaviour.
module tb_spi_flash_responder;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spi_clk = 1'b0;
    logic              spi_cs = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [7:0]        load_data = '0;
    logic              busy;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_mem [256];
    logic [7:0] rx_buf [16];
    int         rx_oe_cnt;

    spi_flash_responder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a read from address a returns store[(a+k) mod 2^ADDR_W] for the k-th byte.
    function automatic logic [7:0] exp_byte(input logic [23:0] a, input int k);
        logic [23:0] ea;
        ea = a + 24'(k);
        return model_mem[ea[7:0]];
    endfunction

    task automatic half_phase();
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_begin();
        spi_clk = 1'b0;
        spi_cs  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        spi_clk = 1'b0;
        spi_cs  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic mo, output logic mi, output logic oe);
        spi_mosi = mo;
        half_phase();
        mi = spi_miso;
        oe = spi_miso_oe;
        spi_clk = 1'b1;
        half_phase();
        spi_clk = 1'b0;
    endtask

    task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx, output int oe_cnt);
        logic mi, oe;
        oe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(tx[i], mi, oe);
            rx[i] = mi;
            if (oe === 1'b1) oe_cnt++;
        end
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        int oc;
        cs_begin();
        byte_xfer(cmd, rx, oc);
        byte_xfer(a[23:16], rx, oc);
        byte_xfer(a[15:8], rx, oc);
        byte_xfer(a[7:0], rx, oc);
    endtask

    task automatic read_bytes(input int n);
        int oc;
        rx_oe_cnt = 0;
        for (int k = 0; k < n; k++) begin
            byte_xfer(8'h00, rx_buf[k], oc);
            rx_oe_cnt += oc;
        end
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got miso/oe/busy=%b expected 000", {spi_miso, spi_miso_oe, busy});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            spi_clk = ~spi_clk;
            half_phase();
            checks++;
            if ({spi_miso, spi_miso_oe, busy} !== 3'b000) begin
                failures++;
                $display("FAIL cs_high_sck_%0d got miso/oe/busy=%b expected 000", i, {spi_miso, spi_miso_oe, busy});
            end
        end
        spi_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_store();
        for (int a = 0; a < 256; a++)
            load_byte(8'(a), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_read_basic();
        load_byte(8'h10, 8'hA5);
        load_byte(8'h11, 8'h3C);
        load_byte(8'h12, 8'hFF);
        load_byte(8'h13, 8'h00);
        send_header(8'h03, 24'h000010);
        read_bytes(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_buf[k] !== exp_byte(24'h000010, k)) begin
                failures++;
                $display("FAIL read_basic_byte%0d got %h expected %h", k, rx_buf[k], exp_byte(24'h000010, k));
            end
        end
        checks++;
        if (rx_oe_cnt != 32) begin
            failures++;
            $display("FAIL read_basic_oe got %0d driven bits expected 32", rx_oe_cnt);
        end
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (spi_miso_oe !== 1'b1) begin
            failures++;
            $display("FAIL oe_hold_2clk got %b expected 1", spi_miso_oe);
        end
        @(negedge clk);
        checks++;
        if ({spi_miso_oe, busy} !== 2'b00) begin
            failures++;
            $display("FAIL oe_fall_3clk got oe/busy=%b expected 00", {spi_miso_oe, busy});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        load_byte(8'hFF, 8'h12);
        load_byte(8'h00, 8'h34);
        send_header(8'h03, 24'h1234FF);
        read_bytes(2);
        checks++;
        if (rx_buf[0] !== 8'h12) begin
            failures++;
            $display("FAIL wrap_byte0 got %h expected 12", rx_buf[0]);
        end
        checks++;
        if (rx_buf[1] !== 8'h34) begin
            failures++;
            $display("FAIL wrap_byte1 got %h expected 34", rx_buf[1]);
        end
        cs_end();
    endtask

    task automatic test_ignore();
        logic [7:0] rx;
        logic mi, oe;
        int oc;
        cs_begin();
        byte_xfer(8'h9F, rx, oc);
        for (int i = 0; i < 16; i++) begin
            bit_xfer(1'b0, mi, oe);
            checks++;
            if ({oe, busy} !== 2'b01) begin
                failures++;
                $display("FAIL ignore_bit%0d got oe/busy=%b expected 01", i, {oe, busy});
            end
        end
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_cs_release got busy=%b expected 0", busy);
        end
        repeat (3) @(negedge clk);
        send_header(8'h03, 24'h000010);
        read_bytes(1);
        checks++;
        if (rx_buf[0] !== exp_byte(24'h000010, 0)) begin
            failures++;
            $display("FAIL after_ignore_read got %h expected %h", rx_buf[0], exp_byte(24'h000010, 0));
        end
        cs_end();
    endtask

    task automatic test_abort();
        logic mi, oe;
        send_header(8'h03, 24'h000010);
        for (int i = 0; i < 5; i++) bit_xfer(1'b0, mi, oe);
        cs_end();
        send_header(8'h03, 24'h000010);
        read_bytes(1);
        checks++;
        if (rx_buf[0] !== exp_byte(24'h000010, 0)) begin
            failures++;
            $display("FAIL abort_cs_read got %h expected %h", rx_buf[0], exp_byte(24'h000010, 0));
        end
        cs_end();
        send_header(8'h03, 24'h000010);
        for (int i = 0; i < 5; i++) bit_xfer(1'b0, mi, oe);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({spi_miso_oe, busy} !== 2'b00) begin
            failures++;
            $display("FAIL abort_rst_outputs got oe/busy=%b expected 00", {spi_miso_oe, busy});
        end
        rst_n = 1'b1;
        cs_end();
        send_header(8'h03, 24'h000010);
        read_bytes(1);
        checks++;
        if (rx_buf[0] !== exp_byte(24'h000010, 0)) begin
            failures++;
            $display("FAIL abort_rst_read got %h expected %h", rx_buf[0], exp_byte(24'h000010, 0));
        end
        cs_end();
    endtask

    task automatic test_fast_read();
        logic mi, oe;
        send_header(8'h0B, 24'h000010);
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b0, mi, oe);
            checks++;
            if (oe !== 1'b0) begin
                failures++;
                $display("FAIL fast_dummy_bit%0d got oe=%b expected 0", i, oe);
            end
        end
        read_bytes(1);
`ifdef SPI_FAST_READ_EN
        checks++;
        if (rx_buf[0] !== exp_byte(24'h000010, 0) || rx_oe_cnt != 8) begin
            failures++;
            $display("FAIL fast_read_data got %h oe_bits=%0d expected %h oe_bits=8",
                     rx_buf[0], rx_oe_cnt, exp_byte(24'h000010, 0));
        end
`else
        checks++;
        if (rx_oe_cnt != 0) begin
            failures++;
            $display("FAIL fast_read_disabled got oe_bits=%0d expected 0", rx_oe_cnt);
        end
`endif
        cs_end();
    endtask

    task automatic test_random();
        logic [23:0] a;
        int n;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1)
                load_byte(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            a = 24'($urandom);
            n = $urandom_range(1, 5);
            send_header(8'h03, a);
            read_bytes(n);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (rx_buf[k] !== exp_byte(a, k)) begin
                    failures++;
                    $display("FAIL random_%0d_byte%0d addr=%h got %h expected %h",
                             it, k, a, rx_buf[k], exp_byte(a, k));
                end
            end
            checks++;
            if (rx_oe_cnt != 8 * n) begin
                failures++;
                $display("FAIL random_%0d_oe got %0d driven bits expected %0d", it, rx_oe_cnt, 8 * n);
            end
            cs_end();
        end
    endtask

    initial begin
        test_reset();
        fill_store();
        test_read_basic();
        test_wrap();
        test_ignore();
        test_abort();
        test_fast_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI flash responder: the far end of the SPI read interface that the RLE VGA top uses to stream run data from external flash. It answers READ (0x03) commands from the design's SPI initiator and serves bytes from an internal loadable byte store. It is used in the bench and in FPGA bring-up in place of a flash model, so RLE streams can be fed without real flash. It oversamples the SPI pins on the system clock and needs no second clock domain.

## Interface
Parameters:
- ADDR_W, 8: store address width; store holds 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- spi_clk  in  1  SPI clock from the initiator; mode 0 (idles low).
- spi_cs  in  1  chip select, active-low.
- spi_mosi  in  1  command and address from the initiator.
- spi_miso  out  1  read data to the initiator.
- spi_miso_oe  out  1  high while the responder drives MISO (DATA state only).
- load_en  in  1  store write strobe, one byte per cycle.
- load_addr  in  ADDR_W  store write address.
- load_data  in  8  store write data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Inputs spi_clk, spi_cs and spi_mosi each pass through a 2-flop synchronizer.
- Rising and falling SCK edges are detected from the synchronized SCK, delayed by one cycle.
- States and transitions:
  - IDLE → CMD when synchronized CS goes low.
  - CMD: shift 8 MOSI bits, MSB first, on SCK rising edges. Cmd 0x03 → ADDR. Any other value → IGNORE.
  - ADDR: shift 24 bits, MSB first. After the 24th bit, → DATA (or → DUMMY, see Configuration).
  - DATA, on each SCK falling edge:
    - If the byte bit count is 0: load mem[addr[ADDR_W-1:0]] into the shift register, drive bit 7, and increment addr.
    - Otherwise: shift left and drive the next bit.
    - The bit count increments on rising edges, modulo 8.
  - IGNORE: MISO is not driven. Stays here until CS goes high.
  - From any state, synchronized CS high → IDLE on the next clk. Shift register, counters and spi_miso_oe clear.
- Address arithmetic:
  - The 24-bit address register increments modulo 2^24.
  - The store index is the low ADDR_W bits, so reads wrap from 2^ADDR_W-1 to 0.
  - Upper address bits are ignored.
- Load port:
  - The write to mem[load_addr] takes effect on the clk edge where load_en=1, in any state.
  - If the same address is fetched in the same cycle, the fetch returns the old byte.
- Reset mid-transaction aborts it. The initiator must raise CS before starting a new command.
- SCK edges seen while CS is high are ignored.
- A transaction ending mid-byte discards the partial byte.

## Timing
- Reset values:
  - spi_miso=0, spi_miso_oe=0, busy=0, state IDLE, counters 0.
  - Store contents are not reset.
- MISO latency: spi_miso updates 4 clk after the SCK falling edge at the pin (2 sync, 1 edge detect, 1 output register).
- spi_miso_oe rises together with the first data bit.
- spi_miso_oe falls 3 clk after CS rises at the pin.
- SCK constraints: each high and each low phase must be at least 6 clk. This keeps MISO stable before the next rising edge.
- CS setup before the first SCK rising edge: at least 4 clk.
- Throughput: one byte per 8 SCK periods, continuous, with no gaps at byte boundaries.

## Configuration
- SPI_FAST_READ_EN defined:
  - Cmd 0x0B is also accepted.
  - After the 24 address bits, state DUMMY counts 8 SCK rising edges with MISO undriven, then → DATA.
  - Data timing is then identical to 0x03.
- SPI_FAST_READ_EN not defined: 0x0B → IGNORE, and the DUMMY state is not built.

## Test plan
- Reset, then hold CS high and toggle SCK 16 times → spi_miso_oe=0, busy=0 throughout, spi_miso=0.
- Load mem[0x10..0x13]=A5,3C,FF,00. Send 03 00 00 10 and clock 32 data bits → MISO returns A5 3C FF 00, MSB first, each bit stable at the SCK rising edge.
- ADDR_W=8, mem[0xFF]=12, mem[0x00]=34. Send 03 12 34 FF and read 2 bytes → 12 34 (wrap; upper address bytes ignored).
- Send cmd 0x9F then 16 clocks → state IGNORE, spi_miso_oe=0. Raise CS → busy=0 within 3 clk. Next 0x03 read works normally.
- Raise CS after 5 data bits, then issue a new read of 0x10 → first byte A5 from bit 7 (no leftover state). Repeat with rst_n pulsed mid-byte → same result.
- With SPI_FAST_READ_EN: send 0B 00 00 10, then 8 dummy clocks → MISO undriven during dummy clocks, then A5. Without the macro: the same sequence → spi_miso_oe stays 0.
